// File: rtl/contador_regressivo.sv
// contador_regressivo: two-digit BCD countdown timer with a one-cycle fim pulse at 00
// Ports: clk, reset_n (async, active-low), carga (load strobe), unid_preset[3:0] (BCD units, >9 clamps to 9),
//        dez_preset[1:0] (tens 0..3), pausa (only with CONTADOR_PAUSA_EN), unid[3:0], dez[1:0], ativo, fim.
// Parameter DIV: clk cycles per count tick (>= 2). Define CONTADOR_PAUSA_EN to add the pausa freeze input.
module contador_regressivo #(
  parameter int DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       carga,
  input  logic [3:0] unid_preset,
  input  logic [1:0] dez_preset,
`ifdef CONTADOR_PAUSA_EN
  input  logic       pausa,
`endif
  output logic [3:0] unid,
  output logic [1:0] dez,
  output logic       ativo,
  output logic       fim
);
  localparam int PW = DIV > 2 ? $clog2(DIV) : 1;
  typedef enum logic [1:0] {OCIOSO, CONTANDO, FIM} state_t;
  state_t state;
  logic [PW-1:0] presc;
  logic hold, tick, zero_load, zero_next;
  logic [3:0] unid_load, unid_dec;
  logic [1:0] dez_dec;
`ifdef CONTADOR_PAUSA_EN
  assign hold = pausa;
`else
  assign hold = 1'b0;
`endif
  always_comb begin
    unid_load = unid_preset > 4'd9 ? 4'd9 : unid_preset;
    zero_load = unid_load == 4'd0 && dez_preset == 2'd0;
    tick      = presc == PW'(DIV - 1);
    unid_dec  = unid != 4'd0 ? unid - 4'd1 : 4'd9;
    dez_dec   = unid != 4'd0 ? dez : dez - 2'd1;
    zero_next = unid == 4'd1 && dez == 2'd0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= OCIOSO;
      presc <= '0;
      unid  <= '0;
      dez   <= '0;
      ativo <= 1'b0;
      fim   <= 1'b0;
    end else if (carga) begin
      unid  <= unid_load;
      dez   <= dez_preset;
      presc <= '0;
      state <= zero_load ? FIM : CONTANDO;
      ativo <= !zero_load;
      fim   <= zero_load;
    end else begin
      case (state)
        CONTANDO: if (!hold) begin
          presc <= tick ? '0 : presc + PW'(1);
          if (tick) begin
            unid <= unid_dec;
            dez  <= dez_dec;
            if (zero_next) begin
              state <= FIM;
              ativo <= 1'b0;
              fim   <= 1'b1;
            end
          end
        end
        FIM: begin
          state <= OCIOSO;
          fim   <= 1'b0;
        end
        OCIOSO: ;
        default: state <= OCIOSO;
      endcase
    end
  end
endmodule

// File: tb/tb_contador_regressivo.sv
// tb_contador_regressivo: randomized and directed check of contador_regressivo against an integer-count model
module tb_contador_regressivo;
  localparam int DIV = 4;
  logic clk = 0, reset_n = 0, carga = 0;
  logic [3:0] unid_preset = 0;
  logic [1:0] dez_preset = 0;
`ifdef CONTADOR_PAUSA_EN
  logic pausa = 0;
`endif
  logic [3:0] unid;
  logic [1:0] dez;
  logic ativo, fim;
  int tests = 0, errors = 0;
  int val = 0, ph = 0, st = 0, act = 0, f = 0;
  always #5 clk = ~clk;
  contador_regressivo #(.DIV(DIV)) dut (
    .clk(clk), .reset_n(reset_n), .carga(carga), .unid_preset(unid_preset), .dez_preset(dez_preset),
`ifdef CONTADOR_PAUSA_EN
    .pausa(pausa),
`endif
    .unid(unid), .dez(dez), .ativo(ativo), .fim(fim)
  );
  task automatic check(string tag, int got, int exp);
    tests++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    check("unid", int'(unid), val % 10);
    check("dez", int'(dez), val / 10);
    check("ativo", int'(ativo), act);
    check("fim", int'(fim), f);
  endtask
  task automatic model_reset();
    val = 0; ph = 0; st = 0; act = 0; f = 0;
  endtask
  task automatic step();
    int p;
    @(posedge clk);
    p = 0;
`ifdef CONTADOR_PAUSA_EN
    p = pausa;
`endif
    if (carga) begin
      val = (unid_preset > 9 ? 9 : int'(unid_preset)) + 10 * int'(dez_preset);
      ph = 0;
      st = val == 0 ? 2 : 1;
      act = val != 0;
      f = val == 0;
    end else if (st == 1) begin
      if (p == 0) begin
        ph++;
        if (ph == DIV) begin
          ph = 0;
          val--;
          if (val == 0) begin st = 2; act = 0; f = 1; end
        end
      end
    end else if (st == 2) begin
      st = 0; f = 0;
    end
    @(negedge clk);
    check_all();
  endtask
  task automatic load(int u, int d);
    carga = 1; unid_preset = 4'(u); dez_preset = 2'(d);
    step();
    carga = 0;
  endtask
  initial begin
    int n;
    repeat (2) @(negedge clk);
    model_reset();
    check_all();
    reset_n = 1;
    load(5, 1);
    check("t2_load", int'(dez) * 10 + int'(unid), 15);
    repeat (4) step();
    check("t2_first", int'(dez) * 10 + int'(unid), 14);
    n = 4;
    while (!fim && n < 200) begin step(); n++; end
    check("t2_len", n, 60);
    step();
    check("t2_fim_once", int'(fim), 0);
    load(0, 0);
    check("t3_fim", int'(fim), 1);
    check("t3_ativo", int'(ativo), 0);
    repeat (3) step();
    load(12, 2);
    check("t4_clamp", int'(dez) * 10 + int'(unid), 29);
    repeat (4) step();
    check("t4_tick", int'(dez) * 10 + int'(unid), 28);
    load(2, 1);
    repeat (2) step();
    load(2, 2);
    check("t5_reload", int'(dez) * 10 + int'(unid), 22);
    repeat (3) step();
    check("t5_hold", int'(dez) * 10 + int'(unid), 22);
    step();
    check("t5_tick", int'(dez) * 10 + int'(unid), 21);
    load(5, 3);
    repeat (7) step();
    #2 reset_n = 0;
    #1 model_reset();
    check_all();
    @(negedge clk) reset_n = 1;
    step();
`ifdef CONTADOR_PAUSA_EN
    load(8, 0);
    repeat (5) step();
    pausa = 1;
    repeat (10) step();
    check("t6_hold", int'(unid), 7);
    check("t6_ativo", int'(ativo), 1);
    pausa = 0;
    repeat (8) step();
    check("t6_resume", int'(unid), 5);
`endif
    repeat (3000) begin
      carga = $urandom_range(0, 59) == 0;
      unid_preset = 4'($urandom_range(0, 15));
      dez_preset = $urandom_range(0, 1) ? 2'd0 : 2'($urandom_range(0, 3));
`ifdef CONTADOR_PAUSA_EN
      pausa = $urandom_range(0, 3) == 0;
`endif
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
